// File: rtl/store_commit_queue_pkg.sv
// Shared types and widths for the commit-side store queue.
package store_commit_queue_pkg;

   localparam int unsigned PLEN = 56;
   localparam int unsigned XLEN = 64;
   localparam int unsigned BEW  = XLEN / 8;

   typedef enum logic [0:0] {
      StIdle,
      StReq
   } scq_state_e;

   typedef struct packed {
      logic [PLEN-1:0] paddr;
      logic [XLEN-1:0] data;
      logic [BEW-1:0]  be;
      logic [1:0]      size;
      logic            valid;
   } st_cq_entry_t;

   // Byte-wise overlay of new data onto old data where be is set.
   function automatic logic [XLEN-1:0] merge_bytes(input logic [XLEN-1:0] old_data,
                                                    input logic [XLEN-1:0] new_data,
                                                    input logic [BEW-1:0]  be);
      logic [XLEN-1:0] res;
      res = old_data;
      for (int i = 0; i < BEW; i++) begin
         if (be[i]) begin
            res[8*i +: 8] = new_data[8*i +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/store_commit_queue_if.sv
// Push (from commit) and write-request (to dcache) channels of the store commit queue.
interface store_commit_queue_if;
   import store_commit_queue_pkg::*;

   logic            push_valid;
   logic            push_ready;
   logic [PLEN-1:0] push_paddr;
   logic [XLEN-1:0] push_data;
   logic [BEW-1:0]  push_be;
   logic [1:0]      push_size;

   logic            req_valid;
   logic            req_gnt;
   logic [PLEN-1:0] req_addr;
   logic [XLEN-1:0] req_data;
   logic [BEW-1:0]  req_be;
   logic [1:0]      req_size;

   modport master (
      output push_valid, push_paddr, push_data, push_be, push_size, req_gnt,
      input  push_ready, req_valid, req_addr, req_data, req_be, req_size
   );

   modport slave (
      input  push_valid, push_paddr, push_data, push_be, push_size, req_gnt,
      output push_ready, req_valid, req_addr, req_data, req_be, req_size
   );

endinterface

// File: rtl/store_commit_queue.sv
// In-order buffer of retired stores with same-word merging, draining to the dcache write port.
module store_commit_queue
   import store_commit_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   store_commit_queue_if.slave        bus,
   input  logic                       stall_i,
   input  logic [11:0]                page_offset_i,
   output logic                       page_offset_matches_o,
   output logic                       empty_o,
   output logic                       no_st_pending_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   st_cq_entry_t    mem_q [DEPTH];
   st_cq_entry_t    mem_d [DEPTH];
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] tail_ptr;
   logic [CntW-1:0] count_q, count_d;
   scq_state_e      state_q, state_d;

   logic            push_ready;
   logic            push_fire;
   logic            merge;
   logic            alloc;
   logic            pop;
   logic            req_valid;
   st_cq_entry_t    head;
   logic [DEPTH-1:0] off_hit;
   logic            unused_bits;

   assign push_ready = (count_q < CntW'(DEPTH));
   assign push_fire  = bus.push_valid && push_ready;
   assign tail_ptr   = wr_ptr_q - PtrW'(1);
   assign req_valid  = (state_q == StReq);
   assign pop        = req_valid && bus.req_gnt;
   assign head       = mem_q[rd_ptr_q];

   // The head is frozen while it is being requested, so it must not absorb a merge.
   assign merge = push_fire && (count_q != '0) &&
                  (bus.push_paddr[PLEN-1:3] == mem_q[tail_ptr].paddr[PLEN-1:3]) &&
                  !(req_valid && (tail_ptr == rd_ptr_q));
   assign alloc = push_fire && !merge;

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q + CntW'(alloc) - CntW'(pop);

      if (pop) begin
         mem_d[rd_ptr_q].valid = 1'b0;
         rd_ptr_d              = rd_ptr_q + PtrW'(1);
      end

      if (merge) begin
         mem_d[tail_ptr].data = merge_bytes(mem_q[tail_ptr].data, bus.push_data, bus.push_be);
         mem_d[tail_ptr].be   = mem_q[tail_ptr].be | bus.push_be;
         mem_d[tail_ptr].size = 2'b11;
      end else if (alloc) begin
         mem_d[wr_ptr_q].paddr = bus.push_paddr;
         mem_d[wr_ptr_q].data  = bus.push_data;
         mem_d[wr_ptr_q].be    = bus.push_be;
         mem_d[wr_ptr_q].size  = bus.push_size;
         mem_d[wr_ptr_q].valid = 1'b1;
         wr_ptr_d              = wr_ptr_q + PtrW'(1);
      end
   end

   // Next-state uses the post-update count so a store pushed this cycle is requested next cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if ((count_d != '0) && !stall_i) begin
               state_d = StReq;
            end
         end
         StReq: begin
            if (pop) begin
               state_d = ((count_d != '0) && !stall_i) ? StReq : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_off_cmp
      assign off_hit[g] = mem_q[g].valid && (mem_q[g].paddr[11:3] == page_offset_i[11:3]);
   end

   assign page_offset_matches_o = (|off_hit) ||
                                  (bus.push_valid &&
                                   (bus.push_paddr[11:3] == page_offset_i[11:3]));

   assign bus.push_ready  = push_ready;
   assign bus.req_valid   = req_valid;
   assign bus.req_addr    = head.paddr;
   assign bus.req_data    = head.data;
   assign bus.req_be      = head.be;
   assign bus.req_size    = head.size;

   assign empty_o         = (count_q == '0);
   assign no_st_pending_o = empty_o && !req_valid;
   assign count_o         = count_q;

   // Only the word index of the load offset takes part in the hazard compare.
   assign unused_bits = ^page_offset_i[2:0];

   push_ready_a: assert property (@(posedge clk_i) disable iff (rst_i)
      bus.push_valid |-> push_ready);

   req_stable_a: assert property (@(posedge clk_i) disable iff (rst_i)
      (req_valid && !bus.req_gnt) |=>
         (req_valid && $stable(head.paddr) && $stable(head.data) &&
          $stable(head.be) && $stable(head.size)));

endmodule
